// File: rtl/axil_sram_master_pkg.sv
// -----------------------------------------------------------------------------
// axil_sram_master_pkg
//  Shared definitions for the SRAM-to-AXI4-Lite initiator: controller state
//  encoding, AXI response codes and a small response-decoding helper.
// -----------------------------------------------------------------------------
package axil_sram_master_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WREQ  = 3'd3,
      ST_WRESP = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Anything other than OKAY is reported to the requester as an error
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY);
   endfunction

endpackage : axil_sram_master_pkg

// File: rtl/axil_sram_master.sv
// -----------------------------------------------------------------------------
// axil_sram_master
//  Converts an SRAM-style req/addr_ok/data_ok request port into single
//  AXI4-Lite read or write transactions. One transaction is outstanding at a
//  time; read data and response status come back with the data_ok pulse.
//
// Ports
//  aclk, aresetn      clock, synchronous active-low reset
//  req/wr/addr/       request side: valid, direction, byte address,
//  wdata/wstrb        write data and byte enables
//  addr_ok            request accepted when req && addr_ok (only in IDLE)
//  data_ok            one-cycle completion pulse
//  rdata/err          read data and error status, valid with data_ok
//  m_axi_ar*/r*       AXI4-Lite read address / read data channels
//  m_axi_aw*/w*/b*    AXI4-Lite write address / write data / response channels
// -----------------------------------------------------------------------------
module axil_sram_master #(
   parameter logic [2:0] PROT      = 3'b000,
   parameter bit         SKIP_ZSTB = 1'b1
) (
   input  logic        aclk,
   input  logic        aresetn,
   // SRAM-style request port
   input  logic        req,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        err,
   // AXI4-Lite read address channel
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   // AXI4-Lite read data channel
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   // AXI4-Lite write address channel
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   // AXI4-Lite write data channel
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   // AXI4-Lite write response channel
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   input  logic [1:0]  m_axi_bresp
);

   import axil_sram_master_pkg::*;

   state_e      state_q,   state_d;
   logic [31:0] addr_q,    addr_d;
   logic [31:0] wdata_q,   wdata_d;
   logic [3:0]  wstrb_q,   wstrb_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q,  wvalid_d;
   logic        rready_q,  rready_d;
   logic        bready_q,  bready_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q,  w_done_d;
   logic        data_ok_q, data_ok_d;
   logic        err_q,     err_d;
   logic [31:0] rdata_q,   rdata_d;

   logic        zstb_skip_s;
   logic        ar_hs_s;
   logic        aw_fin_s;
   logic        w_fin_s;

   // An all-zero strobe write has no effect on the slave, so it can finish locally
   assign zstb_skip_s = (SKIP_ZSTB == 1'b1) && (wstrb == 4'b0000);
   assign ar_hs_s     = arvalid_q && m_axi_arready;
   // A write channel is finished if it completed earlier or handshakes now
   assign aw_fin_s    = aw_done_q || (awvalid_q && m_axi_awready);
   assign w_fin_s     = w_done_q  || (wvalid_q  && m_axi_wready);

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0000_0000;
         wdata_q   <= 32'h0000_0000;
         wstrb_q   <= 4'b0000;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rready_q  <= 1'b0;
         bready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         data_ok_q <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rready_q  <= rready_d;
         bready_q  <= bready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         data_ok_q <= data_ok_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (!wr) begin
                  state_d = ST_RADDR;
               end else if (zstb_skip_s) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WREQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RADDR: begin
            if (ar_hs_s) begin
               state_d = ST_RDATA;
            end else begin
               state_d = ST_RADDR;
            end
         end
         ST_RDATA: begin
            if (m_axi_rvalid) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RDATA;
            end
         end
         ST_WREQ: begin
            if (aw_fin_s && w_fin_s) begin
               state_d = ST_WRESP;
            end else begin
               state_d = ST_WREQ;
            end
         end
         ST_WRESP: begin
            if (m_axi_bvalid) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRESP;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, capture registers and channel flags
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      rready_d  = 1'b0;
      bready_d  = 1'b0;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      data_ok_d = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d = addr;
               if (!wr) begin
                  arvalid_d = 1'b1;
               end else begin
                  // Write payload is only captured for writes so reads leave the
                  // W channel lines untouched
                  wdata_d = wdata;
                  wstrb_d = wstrb;
                  if (zstb_skip_s) begin
                     data_ok_d = 1'b1;
                     err_d     = 1'b0;
                  end else begin
                     awvalid_d = 1'b1;
                     wvalid_d  = 1'b1;
                     aw_done_d = 1'b0;
                     w_done_d  = 1'b0;
                  end
               end
            end else begin
               addr_d = addr_q;
            end
         end
         ST_RADDR: begin
            arvalid_d = !ar_hs_s;
            rready_d  = ar_hs_s;
         end
         ST_RDATA: begin
            if (m_axi_rvalid) begin
               rdata_d   = m_axi_rdata;
               err_d     = resp_is_err(m_axi_rresp);
               data_ok_d = 1'b1;
               rready_d  = 1'b0;
            end else begin
               rready_d  = 1'b1;
            end
         end
         ST_WREQ: begin
            // AW and W retire independently; each valid drops after its own handshake
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q  && !m_axi_wready;
            aw_done_d = aw_fin_s;
            w_done_d  = w_fin_s;
            bready_d  = aw_fin_s && w_fin_s;
         end
         ST_WRESP: begin
            if (m_axi_bvalid) begin
               err_d     = resp_is_err(m_axi_bresp);
               data_ok_d = 1'b1;
               bready_d  = 1'b0;
            end else begin
               bready_d  = 1'b1;
            end
         end
         ST_DONE: begin
            data_ok_d = 1'b0;
         end
         default: begin
            data_ok_d = 1'b0;
         end
      endcase
   end

   assign addr_ok       = (state_q == ST_IDLE);
   assign data_ok       = data_ok_q;
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = PROT;
   assign m_axi_rready  = rready_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = PROT;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bready_q;

endmodule : axil_sram_master

// File: tb/tb_axil_sram_master.sv
// -----------------------------------------------------------------------------
// tb_axil_sram_master
//  Self-checking bench for axil_sram_master. The bench plays the AXI4-Lite
//  slave cycle by cycle with per-channel ready/response delays and predicts
//  each transaction's outcome (latency, data, error, valid durations) from
//  the transaction parameters with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_axil_sram_master;

   logic        aclk;
   logic        aresetn;
   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [1:0]  m_axi_bresp;

   int n_checks = 0;
   int n_errors = 0;

   axil_sram_master #(
      .PROT      (3'b000),
      .SKIP_ZSTB (1'b1)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req           (req),
      .wr            (wr),
      .addr          (addr),
      .wdata         (wdata),
      .wstrb         (wstrb),
      .addr_ok       (addr_ok),
      .data_ok       (data_ok),
      .rdata         (rdata),
      .err           (err),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_bresp   (m_axi_bresp)
   );

   // Free-running clock
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = 32'h0;
      m_axi_rresp   = 2'b00;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
   endtask

   // Reference: cycles from acceptance to the data_ok pulse
   function automatic int exp_latency(input bit t_wr, input bit skip, input int ar_dly,
                                      input int aw_dly, input int w_dly, input int rsp_dly);
      if (!t_wr) return 3 + ar_dly + rsp_dly;
      if (skip)  return 1;
      return 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + rsp_dly;
   endfunction

   // One request played against a bench-side slave. Called just after a
   // falling edge; returns just after a falling edge.
   task automatic run_txn(input string tag, input bit t_wr, input logic [31:0] t_addr,
                          input logic [31:0] t_wdata, input logic [3:0] t_wstrb,
                          input int ar_dly, input int aw_dly, input int w_dly,
                          input int rsp_dly, input logic [1:0] rsp,
                          input logic [31:0] t_rdata, input bit hold_req);
      bit          skip;
      bit          accepted, ar_hs, aw_hs, w_hs, r_hs, b_hs;
      int          acc_c, dok_c, dok_n, ar_n, aw_n, w_n, bad_pay, bad_aok, r_wait, b_wait;
      logic [31:0] got_rdata;
      logic        got_err;
      skip     = t_wr && (t_wstrb == 4'b0000);
      accepted = 1'b0;
      ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; r_hs = 1'b0; b_hs = 1'b0;
      acc_c = 0; dok_c = 0; dok_n = 0; ar_n = 0; aw_n = 0; w_n = 0;
      bad_pay = 0; bad_aok = 0; r_wait = 0; b_wait = 0;
      got_rdata = 32'h0; got_err = 1'b0;
      wr    = t_wr;
      addr  = t_addr;
      wdata = t_wdata;
      wstrb = t_wstrb;
      for (int c = 0; c < 200; c++) begin
         req = hold_req || !accepted;
         if (accepted && (dok_n == 0) && addr_ok) bad_aok++;
         if (!accepted && addr_ok) begin
            accepted = 1'b1;
            acc_c    = c;
         end
         if (data_ok) begin
            dok_n++;
            if (dok_n == 1) begin
               dok_c     = c;
               got_rdata = rdata;
               got_err   = err;
            end
         end
         if (m_axi_arvalid) begin
            ar_n++;
            if ((m_axi_araddr !== t_addr) || (m_axi_arprot !== 3'b000)) bad_pay++;
         end
         if (m_axi_awvalid) begin
            aw_n++;
            if ((m_axi_awaddr !== t_addr) || (m_axi_awprot !== 3'b000)) bad_pay++;
         end
         if (m_axi_wvalid) begin
            w_n++;
            if ((m_axi_wdata !== t_wdata) || (m_axi_wstrb !== t_wstrb)) bad_pay++;
         end
         // Slave response for this cycle
         m_axi_arready = m_axi_arvalid && (ar_n > ar_dly);
         m_axi_awready = m_axi_awvalid && (aw_n > aw_dly);
         m_axi_wready  = m_axi_wvalid  && (w_n  > w_dly);
         m_axi_rvalid  = ar_hs && !r_hs && (r_wait >= rsp_dly);
         m_axi_rdata   = m_axi_rvalid ? t_rdata : ~t_rdata;
         m_axi_rresp   = m_axi_rvalid ? rsp : 2'b00;
         m_axi_bvalid  = aw_hs && w_hs && !b_hs && (b_wait >= rsp_dly);
         m_axi_bresp   = m_axi_bvalid ? rsp : 2'b00;
         #1;
         if (ar_hs && !r_hs) r_wait++;
         if (aw_hs && w_hs && !b_hs) b_wait++;
         if (m_axi_rvalid && m_axi_rready) r_hs = 1'b1;
         if (m_axi_bvalid && m_axi_bready) b_hs = 1'b1;
         if (m_axi_arvalid && m_axi_arready) ar_hs = 1'b1;
         if (m_axi_awvalid && m_axi_awready) aw_hs = 1'b1;
         if (m_axi_wvalid && m_axi_wready) w_hs = 1'b1;
         if ((dok_n > 0) && (hold_req || (c == dok_c + 1))) break;
         @(negedge aclk);
      end
      slave_idle();
      if (!hold_req) req = 1'b0;
      @(negedge aclk);
      chk({tag, " data_ok count"}, dok_n, 1);
      chk({tag, " latency"}, dok_c - acc_c, exp_latency(t_wr, skip, ar_dly, aw_dly, w_dly, rsp_dly));
      chk({tag, " err"}, got_err, (rsp != 2'b00) && !skip);
      if (!t_wr) chk({tag, " rdata"}, got_rdata, t_rdata);
      chk({tag, " arvalid cycles"}, ar_n, t_wr ? 0 : ar_dly + 1);
      chk({tag, " awvalid cycles"}, aw_n, (t_wr && !skip) ? aw_dly + 1 : 0);
      chk({tag, " wvalid cycles"}, w_n, (t_wr && !skip) ? w_dly + 1 : 0);
      chk({tag, " payload stable"}, bad_pay, 0);
      chk({tag, " addr_ok while busy"}, bad_aok, 0);
   endtask

   // Directed steps followed by randomized transactions
   initial begin
      logic [1:0] rsp_sel;
      aresetn = 1'b0;
      req = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'b0000;
      slave_idle();
      repeat (3) @(negedge aclk);
      chk("reset valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b00000);
      chk("reset data_ok/err", {data_ok, err}, 2'b00);
      chk("reset rdata", rdata, 32'h0);
      chk("reset addr_ok", addr_ok, 1'b1);
      aresetn = 1'b1;
      @(negedge aclk);

      run_txn("rd zero-wait", 1'b0, 32'h1FD0_F010, 32'h0, 4'b0000, 0, 0, 0, 0,
              axil_sram_master_pkg::RESP_OKAY, 32'h0123_4567, 1'b0);
      run_txn("wr aw late", 1'b1, 32'h1FD0_F020, 32'hDEAD_BEEF, 4'b0011, 0, 2, 0, 0,
              axil_sram_master_pkg::RESP_OKAY, 32'h0, 1'b0);
      run_txn("rd ar slow slverr", 1'b0, 32'h1FD0_F030, 32'h0, 4'b0000, 5, 0, 0, 0,
              axil_sram_master_pkg::RESP_SLVERR, 32'hCAFE_0001, 1'b0);
      run_txn("wr zero strobe", 1'b1, 32'h1FD0_F040, 32'h5555_AAAA, 4'b0000, 0, 0, 0, 0,
              axil_sram_master_pkg::RESP_DECERR, 32'h0, 1'b0);

      // Back-to-back with req held high
      run_txn("b2b rd", 1'b0, 32'h0000_1000, 32'h0, 4'b0000, 1, 0, 0, 1,
              axil_sram_master_pkg::RESP_OKAY, 32'h1111_2222, 1'b1);
      run_txn("b2b wr", 1'b1, 32'h0000_1004, 32'h3333_4444, 4'b1111, 0, 0, 2, 0,
              axil_sram_master_pkg::RESP_DECERR, 32'h0, 1'b1);
      run_txn("b2b rd2", 1'b0, 32'h0000_1008, 32'h0, 4'b0000, 0, 0, 0, 0,
              axil_sram_master_pkg::RESP_OKAY, 32'h5555_6666, 1'b0);

      // Stray read data while idle must be ignored
      for (int i = 0; i < 3; i++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = 32'hBAD0_0000 + i;
         m_axi_rresp  = 2'b10;
         @(negedge aclk);
         chk("stray rvalid", {m_axi_rready, data_ok, addr_ok}, 3'b001);
      end
      slave_idle();
      @(negedge aclk);
      chk("stray rvalid rdata kept", rdata, 32'h5555_6666);

      // Reset while the write channels are stalled
      req = 1'b1; wr = 1'b1; addr = 32'h0000_2000; wdata = 32'h7777_8888; wstrb = 4'b1111;
      @(negedge aclk);
      req = 1'b0;
      @(negedge aclk);
      chk("mid-reset write active", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      aresetn = 1'b0;
      @(negedge aclk);
      chk("mid-reset valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b00000);
      chk("mid-reset data_ok/err/rdata", {data_ok, err, rdata}, 34'h0);
      aresetn = 1'b1;
      @(negedge aclk);
      run_txn("rd after reset", 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 0, 0, 0, 0,
              axil_sram_master_pkg::RESP_OKAY, 32'h9ABC_DEF0, 1'b0);

      // Randomized transactions
      for (int n = 0; n < 30; n++) begin
         logic [3:0] rs;
         rsp_sel = 2'($urandom_range(0, 3));
         rs = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         run_txn($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), $urandom, $urandom, rs,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), rsp_sel, $urandom, 1'($urandom_range(0, 1)));
      end
      req = 1'b0;
      repeat (4) @(negedge aclk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_axil_sram_master
